// File: rtl/inv_sqrt_arbiter.sv
// Round-robin front end sharing one inverse-square-root engine among N_REQ requesters, one job in flight.
// Latency: req_ready pulse -> eng_valid_in next cycle; results are held on rsp_valid until the owner takes them.
module inv_sqrt_arbiter #(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4,
    parameter int N_REQ       = 3,
    parameter int TIMEOUT     = 255,
    localparam int W  = INT_WIDTH + FRACT_WIDTH,
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_err,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [W-1:0]         eng_data_in,
    output logic                 eng_valid_in,
    input  logic                 eng_ready_in,
    input  logic [W-1:0]         eng_data_out,
    input  logic                 eng_valid_out,
    output logic                 eng_ready_out,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RETURN
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [CW-1:0]   wait_cnt;
    logic [GW-1:0]   pick_idx;

    // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                pick_idx = GW'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (GW'(i) > last_grant)) begin
                pick_idx = GW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            eng_data_in   <= '0;
            eng_valid_in  <= 1'b0;
            eng_ready_out <= 1'b0;
            busy          <= 1'b0;
            grant_id      <= '0;
            wait_cnt      <= '0;
            last_grant    <= GW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        req_ready   <= N_REQ'(1) << pick_idx;
                        grant_id    <= pick_idx;
                        eng_data_in <= req_data[int'(pick_idx)*W +: W];
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (req_ready != '0) begin
                        // The req_ready cycle is the acceptance point; a withdrawn request is dropped.
                        req_ready <= '0;
                        if (req_valid[grant_id]) begin
                            eng_valid_in <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (eng_ready_in) begin
                        eng_valid_in  <= 1'b0;
                        eng_ready_out <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= WAIT;
                    end
                end

                WAIT: begin
                    if (eng_valid_out) begin
                        rsp_data      <= eng_data_out;
                        rsp_err       <= 1'b0;
                        eng_ready_out <= 1'b0;
                        rsp_valid     <= N_REQ'(1) << grant_id;
                        state         <= RETURN;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_data      <= '0;
                        rsp_err       <= 1'b1;
                        eng_ready_out <= 1'b0;
                        rsp_valid     <= N_REQ'(1) << grant_id;
                        state         <= RETURN;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                RETURN: begin
                    if (rsp_ready[grant_id]) begin
                        last_grant <= grant_id;
                        rsp_valid  <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// Directed bench for inv_sqrt_arbiter: a default-timeout instance for the main flow and a TIMEOUT=8 instance.
module tb_inv_sqrt_arbiter;

    localparam int W = 16;
    localparam int N = 3;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   rsp_ready;
    logic           eng_ready_in;
    logic [W-1:0]   eng_data_out;
    logic           eng_valid_out;
    logic [W-1:0]   eng_data_out8;
    logic           eng_valid_out8;

    logic [N-1:0]   req_ready, rsp_valid;
    logic [W-1:0]   rsp_data, eng_data_in;
    logic           rsp_err, eng_valid_in, eng_ready_out, busy;
    logic [1:0]     grant_id;

    logic [N-1:0]   req_ready8, rsp_valid8;
    logic [W-1:0]   rsp_data8, eng_data_in8;
    logic           rsp_err8, eng_valid_in8, eng_ready_out8, busy8;
    logic [1:0]     grant_id8;

    int n_cmp = 0;
    int n_err = 0;

    inv_sqrt_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .eng_data_in(eng_data_in), .eng_valid_in(eng_valid_in), .eng_ready_in(eng_ready_in),
        .eng_data_out(eng_data_out), .eng_valid_out(eng_valid_out), .eng_ready_out(eng_ready_out),
        .busy(busy), .grant_id(grant_id)
    );

    inv_sqrt_arbiter #(.TIMEOUT(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready8),
        .rsp_valid(rsp_valid8), .rsp_data(rsp_data8), .rsp_err(rsp_err8), .rsp_ready(rsp_ready),
        .eng_data_in(eng_data_in8), .eng_valid_in(eng_valid_in8), .eng_ready_in(eng_ready_in),
        .eng_data_out(eng_data_out8), .eng_valid_out(eng_valid_out8), .eng_ready_out(eng_ready_out8),
        .busy(busy8), .grant_id(grant_id8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        req_valid      = '0;
        rsp_ready      = '0;
        eng_valid_out  = 1'b0;
        eng_valid_out8 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_eng_valid_in"}, eng_valid_in, 0);
        chk({tag, "_eng_ready_out"}, eng_ready_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_eng_data_in"}, eng_data_in, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
    endtask

    // Full transaction with an immediately answering engine; entered with the arbiter in IDLE.
    task automatic serve(input string tag, input int id, input logic [W-1:0] opnd, input logic [W-1:0] res);
        step();
        chk({tag, "_grant"}, req_ready, 64'd1 << id);
        chk({tag, "_grant_id"}, grant_id, id);
        step();
        chk({tag, "_ready_pulse"}, req_ready, 0);
        chk({tag, "_issue_vld"}, eng_valid_in, 1);
        chk({tag, "_issue_dat"}, eng_data_in, opnd);
        step();
        chk({tag, "_wait_rdy"}, eng_ready_out, 1);
        eng_valid_out = 1'b1;
        eng_data_out  = res;
        step();
        eng_valid_out = 1'b0;
        chk({tag, "_rsp_vld"}, rsp_valid, 64'd1 << id);
        chk({tag, "_rsp_dat"}, rsp_data, res);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        step();
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_no_grant"}, req_ready, 0);
        chk({tag, "_idle_rsp_vld"}, rsp_valid, 0);
    endtask

    initial begin
        req_data      = '0;
        eng_ready_in  = 1'b1;
        eng_data_out  = '0;
        eng_data_out8 = '0;

        // Reset state
        do_reset();
        chk_reset_outputs("rst0");
        step();
        chk("rst0_idle_busy", busy, 0);

        // Single request, engine answers after 10 WAIT cycles
        do_reset();
        req_valid = 3'b001;
        req_data[0*W +: W] = 16'h0040;
        step();
        chk("single_grant", req_ready, 3'b001);
        chk("single_grant_id", grant_id, 0);
        chk("single_busy", busy, 1);
        chk("single_no_vld_yet", eng_valid_in, 0);
        step();
        chk("single_ready_pulse", req_ready, 0);
        chk("single_issue_vld", eng_valid_in, 1);
        chk("single_issue_dat", eng_data_in, 16'h0040);
        req_valid = 3'b000;
        step();
        chk("single_wait_vld", eng_valid_in, 0);
        chk("single_wait_rdy", eng_ready_out, 1);
        repeat (9) step();
        chk("single_wait_no_rsp", rsp_valid, 0);
        eng_valid_out = 1'b1;
        eng_data_out  = 16'h0008;
        step();
        eng_valid_out = 1'b0;
        chk("single_rsp_vld", rsp_valid, 3'b001);
        chk("single_rsp_dat", rsp_data, 16'h0008);
        chk("single_rsp_err", rsp_err, 0);
        chk("single_rsp_eng_rdy", eng_ready_out, 0);
        step();
        chk("single_rsp_hold", rsp_valid, 3'b001);
        rsp_ready = 3'b001;
        step();
        chk("single_done_vld", rsp_valid, 0);
        chk("single_done_busy", busy, 0);

        // All three requesting continuously: order 0,1,2,0
        do_reset();
        req_data[0*W +: W] = 16'h0100;
        req_data[1*W +: W] = 16'h0190;
        req_data[2*W +: W] = 16'h0400;
        req_valid = 3'b111;
        rsp_ready = 3'b111;
        serve("rr0", 0, 16'h0100, 16'h0004);
        serve("rr1", 1, 16'h0190, 16'h0003);
        serve("rr2", 2, 16'h0400, 16'h0002);
        serve("rr3", 0, 16'h0100, 16'h0004);
        req_valid = 3'b000;
        rsp_ready = 3'b000;

        // Engine stalls the operand for 5 cycles
        do_reset();
        req_data[1*W +: W] = 16'h0900;
        req_valid    = 3'b010;
        eng_ready_in = 1'b0;
        step();
        chk("stall_grant", req_ready, 3'b010);
        chk("stall_grant_id", grant_id, 1);
        step();
        chk("stall_issue_vld", eng_valid_in, 1);
        chk("stall_issue_dat", eng_data_in, 16'h0900);
        req_valid = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold_vld", eng_valid_in, 1);
            chk("stall_hold_dat", eng_data_in, 16'h0900);
            chk("stall_not_wait", eng_ready_out, 0);
        end
        eng_ready_in = 1'b1;
        step();
        chk("stall_wait_vld", eng_valid_in, 0);
        chk("stall_wait_rdy", eng_ready_out, 1);
        eng_valid_out = 1'b1;
        eng_data_out  = 16'h0001;
        step();
        eng_valid_out = 1'b0;
        chk("stall_rsp_vld", rsp_valid, 3'b010);
        chk("stall_rsp_dat", rsp_data, 16'h0001);
        rsp_ready = 3'b010;
        step();
        chk("stall_done_busy", busy, 0);
        rsp_ready = 3'b000;

        // Owner withholds rsp_ready; the others' rsp_ready must not release it
        req_data[0*W +: W] = 16'h0100;
        req_data[2*W +: W] = 16'h0400;
        req_valid = 3'b101;
        step();
        chk("hold_grant", req_ready, 3'b100);
        chk("hold_grant_id", grant_id, 2);
        step();
        chk("hold_issue_dat", eng_data_in, 16'h0400);
        step();
        eng_valid_out = 1'b1;
        eng_data_out  = 16'h0002;
        step();
        eng_valid_out = 1'b0;
        chk("hold_rsp_vld", rsp_valid, 3'b100);
        rsp_ready = 3'b011;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("hold_rsp_vld_kept", rsp_valid, 3'b100);
            chk("hold_busy", busy, 1);
            chk("hold_no_grant", req_ready, 0);
            chk("hold_rsp_dat", rsp_data, 16'h0002);
        end
        rsp_ready = 3'b100;
        step();
        chk("hold_release_vld", rsp_valid, 0);
        chk("hold_release_busy", busy, 0);
        chk("hold_release_no_grant", req_ready, 0);
        step();
        chk("hold_next_grant", req_ready, 3'b001);
        chk("hold_next_grant_id", grant_id, 0);
        req_valid = 3'b000;
        rsp_ready = 3'b000;

        // TIMEOUT=8 instance: one normal result, then a timeout, then stray results
        do_reset();
        req_data[0*W +: W] = 16'h0010;
        req_valid = 3'b001;
        step();
        chk("to_grant0", req_ready8, 3'b001);
        step();
        chk("to_issue0_vld", eng_valid_in8, 1);
        chk("to_issue0_dat", eng_data_in8, 16'h0010);
        req_valid = 3'b000;
        step();
        chk("to_wait0_rdy", eng_ready_out8, 1);
        eng_valid_out8 = 1'b1;
        eng_data_out8  = 16'h0010;
        step();
        eng_valid_out8 = 1'b0;
        chk("to_rsp0_vld", rsp_valid8, 3'b001);
        chk("to_rsp0_dat", rsp_data8, 16'h0010);
        chk("to_rsp0_err", rsp_err8, 0);
        rsp_ready = 3'b001;
        step();
        chk("to_idle0_vld", rsp_valid8, 0);
        rsp_ready = 3'b000;
        req_data[1*W +: W] = 16'h0040;
        req_valid = 3'b010;
        step();
        chk("to_grant1", req_ready8, 3'b010);
        chk("to_grant1_id", grant_id8, 1);
        step();
        chk("to_issue1_vld", eng_valid_in8, 1);
        req_valid = 3'b000;
        step();
        chk("to_wait1_rdy", eng_ready_out8, 1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_wait1_no_rsp", rsp_valid8, 0);
        end
        step();
        chk("to_rsp1_vld", rsp_valid8, 3'b010);
        chk("to_rsp1_dat", rsp_data8, 0);
        chk("to_rsp1_err", rsp_err8, 1);
        chk("to_rsp1_eng_rdy", eng_ready_out8, 0);
        eng_valid_out8 = 1'b1;
        eng_data_out8  = 16'h7777;
        step();
        chk("to_stray_ret_dat", rsp_data8, 0);
        chk("to_stray_ret_err", rsp_err8, 1);
        chk("to_stray_ret_vld", rsp_valid8, 3'b010);
        eng_valid_out8 = 1'b0;
        rsp_ready = 3'b010;
        step();
        chk("to_idle1_vld", rsp_valid8, 0);
        chk("to_idle1_busy", busy8, 0);
        rsp_ready = 3'b000;
        eng_valid_out8 = 1'b1;
        eng_data_out8  = 16'h5555;
        step();
        chk("to_stray_idle_dat", rsp_data8, 0);
        eng_valid_out8 = 1'b0;

        // Reset during WAIT, then a normal request from requester 0
        do_reset();
        req_data[0*W +: W] = 16'h0040;
        req_valid = 3'b001;
        step();
        step();
        step();
        chk("mid_wait_rdy", eng_ready_out, 1);
        step();
        rst = 1'b1;
        req_valid = 3'b000;
        step();
        chk_reset_outputs("mid_rst");
        eng_valid_out = 1'b1;
        eng_data_out  = 16'h9999;
        step();
        rst = 1'b0;
        step();
        chk("mid_stray_dat", rsp_data, 0);
        chk("mid_stray_vld", rsp_valid, 0);
        chk("mid_stray_busy", busy, 0);
        eng_valid_out = 1'b0;
        req_data[0*W +: W] = 16'h0400;
        req_valid = 3'b001;
        rsp_ready = 3'b111;
        serve("mid_after", 0, 16'h0400, 16'h0002);
        req_valid = 3'b000;
        rsp_ready = 3'b000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
